// File: rtl/wavetable_pkg.sv
// Shared widths, types, FSM encodings and the mix saturation helper
// for the wavetable voice scheduler.
package wavetable_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 12;
  localparam int PHASE_W = 24;
  // Widest accumulator the scheduler can need (16 voices).
  localparam int SAT_W   = DATA_W + 4;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic [PHASE_W-1:0]       phase_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  function automatic sample_t saturate(input logic signed [SAT_W-1:0] v);
    logic [SAT_W-DATA_W:0] top_bits;
    top_bits = v[SAT_W-1:DATA_W-1];
    if ((&top_bits) || !(|top_bits))
      return sample_t'(v[DATA_W-1:0]);
    else if (v[SAT_W-1])
      return sample_t'({1'b1, {(DATA_W-1){1'b0}}});
    else
      return sample_t'({1'b0, {(DATA_W-1){1'b1}}});
  endfunction

endpackage

// File: rtl/wavetable_phase_bank.sv
// Per-voice config and phase registers with one indexed read port and a
// step strobe that advances the addressed voice by freq*(harm+1).
module wavetable_phase_bank
  import wavetable_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 24
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          wr_we,
  input  logic [$clog2(NUM_VOICES)-1:0] wr_voice,
  input  logic                          wr_en,
  input  logic [PHASE_W-1:0]            wr_freq,
  input  logic [1:0]                    wr_harm,
  input  logic [$clog2(NUM_VOICES)-1:0] rd_voice,
  input  logic                          step,
  output logic                          rd_en,
  output logic [PHASE_W-1:0]            rd_phase
);

  localparam int VW = $clog2(NUM_VOICES);

  logic               en_vec    [NUM_VOICES];
  logic [PHASE_W-1:0] phase_vec [NUM_VOICES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi = gi + 1) begin : g_voice
      logic               en_reg;
      logic [1:0]         harm_reg;
      logic [PHASE_W-1:0] freq_reg;
      logic [PHASE_W-1:0] phase_reg;
      logic [PHASE_W-1:0] inc;
      logic               wr_hit;
      logic               step_hit;

      assign wr_hit   = wr_we && (wr_voice == VW'(gi));
      assign step_hit = step && en_reg && (rd_voice == VW'(gi));

      // Multiplier is only 1..4, so shift-add is enough.
      always_comb begin
        case (harm_reg)
          2'd0:    inc = freq_reg;
          2'd1:    inc = freq_reg << 1;
          2'd2:    inc = (freq_reg << 1) + freq_reg;
          default: inc = freq_reg << 2;
        endcase
      end

      always_ff @(posedge Clk) begin
        if (!Reset) begin
          en_reg    <= 1'b0;
          harm_reg  <= 2'd0;
          freq_reg  <= '0;
          phase_reg <= '0;
        end else begin
          if (wr_hit) begin
            en_reg   <= wr_en;
            freq_reg <= wr_freq;
            harm_reg <= wr_harm;
          end
          // A disabling write restarts the voice and beats a same-cycle step.
          if (wr_hit && !wr_en)
            phase_reg <= '0;
          else if (step_hit)
            phase_reg <= phase_reg + inc;
        end
      end

      assign en_vec[gi]    = en_reg;
      assign phase_vec[gi] = phase_reg;
    end
  endgenerate

  assign rd_en    = en_vec[rd_voice];
  assign rd_phase = phase_vec[rd_voice];

endmodule

// File: rtl/wavetable_voice_scheduler.sv
// Scans all voices once per sample strobe through one shared ROM port and
// produces a saturated mix of the returned samples.
module wavetable_voice_scheduler
  import wavetable_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = wavetable_pkg::PHASE_W,
  parameter int ADDR_W     = wavetable_pkg::ADDR_W,
  parameter int DATA_W     = wavetable_pkg::DATA_W
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          sample_Clk,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
  input  logic                          cfg_en,
  input  logic [PHASE_W-1:0]            cfg_freq,
  input  logic [1:0]                    cfg_harm,
  input  logic                          ovr_clr,
  output logic                          rom_rd,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [DATA_W-1:0]             rom_data,
  output logic [DATA_W-1:0]             mix_out,
  output logic                          mix_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int VW    = $clog2(NUM_VOICES);
  localparam int ACC_W = DATA_W + VW;

  logic [1:0]               state_reg;
  logic [VW-1:0]            idx_reg;
  logic                     rom_rd_reg;
  logic [ADDR_W-1:0]        rom_addr_reg;
  logic                     rd_d_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [DATA_W-1:0]        mix_reg;
  logic                     mix_valid_reg;
  logic                     ovr_reg;

  logic                     last_voice;
  logic                     issue_go;
  logic [VW-1:0]            issue_voice;
  logic                     issue_en;
  logic [PHASE_W-1:0]       issue_phase;
  logic signed [ACC_W-1:0]  acc_sum;

  // rom_rd is registered, so the voice issued at an edge is one ahead of idx_reg.
  assign last_voice  = (idx_reg == VW'(NUM_VOICES - 1));
  assign issue_go    = ((state_reg == ST_IDLE) && sample_Clk) ||
                       ((state_reg == ST_SCAN) && !last_voice);
  assign issue_voice = (state_reg == ST_IDLE) ? '0 : VW'(idx_reg + 1'b1);

  wavetable_phase_bank #(
    .NUM_VOICES (NUM_VOICES),
    .PHASE_W    (PHASE_W)
  ) u_bank (
    .Clk      (Clk),
    .Reset    (Reset),
    .wr_we    (cfg_we),
    .wr_voice (cfg_voice),
    .wr_en    (cfg_en),
    .wr_freq  (cfg_freq),
    .wr_harm  (cfg_harm),
    .rd_voice (issue_voice),
    .step     (issue_go),
    .rd_en    (issue_en),
    .rd_phase (issue_phase)
  );

  always_comb begin
    acc_sum = acc_reg + (rd_d_reg ? ACC_W'(signed'(rom_data)) : '0);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      rom_rd_reg    <= 1'b0;
      rom_addr_reg  <= '0;
      rd_d_reg      <= 1'b0;
      acc_reg       <= '0;
      mix_reg       <= '0;
      mix_valid_reg <= 1'b0;
      ovr_reg       <= 1'b0;
    end else begin
      mix_valid_reg <= 1'b0;
      rd_d_reg      <= rom_rd_reg;
      rom_rd_reg    <= issue_go ? issue_en : 1'b0;
      if (issue_go && issue_en)
        rom_addr_reg <= issue_phase[PHASE_W-1 -: ADDR_W];

      case (state_reg)
        ST_IDLE: begin
          if (sample_Clk) begin
            state_reg <= ST_SCAN;
            idx_reg   <= '0;
            acc_reg   <= '0;
          end
        end
        ST_SCAN: begin
          acc_reg <= acc_sum;
          if (last_voice)
            state_reg <= ST_DRAIN;
          else
            idx_reg <= VW'(idx_reg + 1'b1);
        end
        ST_DRAIN: begin
          acc_reg       <= acc_sum;
          mix_reg       <= saturate(SAT_W'(acc_sum));
          mix_valid_reg <= 1'b1;
          state_reg     <= ST_OUT;
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (sample_Clk && (state_reg != ST_IDLE))
        ovr_reg <= 1'b1;
      else if (ovr_clr)
        ovr_reg <= 1'b0;
    end
  end

  assign rom_rd    = rom_rd_reg;
  assign rom_addr  = rom_addr_reg;
  assign mix_out   = mix_reg;
  assign mix_valid = mix_valid_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign overrun   = ovr_reg;

endmodule

// File: tb/tb_wavetable_voice_scheduler.sv
// Self-checking bench: behavioural voice model, registered ROM model and a
// scoreboard of expected mixes consumed whenever mix_valid pulses.
module tb_wavetable_voice_scheduler;

  localparam int NV = 8;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        sample_Clk = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_voice = '0;
  logic        cfg_en = 1'b0;
  logic [23:0] cfg_freq = '0;
  logic [1:0]  cfg_harm = '0;
  logic        ovr_clr = 1'b0;
  logic        rom_rd;
  logic [11:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic [15:0] mix_out;
  logic        mix_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  bit          rom_ident = 1'b1;
  logic [15:0] rom_const = '0;

  bit          m_en    [NV];
  logic [23:0] m_freq  [NV];
  logic [23:0] m_phase [NV];
  logic [1:0]  m_harm  [NV];

  wavetable_voice_scheduler #(
    .NUM_VOICES (NV),
    .PHASE_W    (24),
    .ADDR_W     (12),
    .DATA_W     (16)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .sample_Clk (sample_Clk),
    .cfg_we     (cfg_we),
    .cfg_voice  (cfg_voice),
    .cfg_en     (cfg_en),
    .cfg_freq   (cfg_freq),
    .cfg_harm   (cfg_harm),
    .ovr_clr    (ovr_clr),
    .rom_rd     (rom_rd),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .mix_out    (mix_out),
    .mix_valid  (mix_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 Clk = ~Clk;

  // ROM answers one cycle after the address is presented.
  always @(posedge Clk) rom_data <= rom_ident ? {4'h0, rom_addr} : rom_const;

  function automatic logic [15:0] sat16(input int s);
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  always @(negedge Clk) begin
    if (mix_valid === 1'b1) begin
      logic [15:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mix_unexpected: mix_valid=1 mix_out=%h, required no pulse", mix_out);
      end else begin
        e = exp_q.pop_front();
        $display("txn mix_out=%h expected=%h", mix_out, e);
        if (mix_out !== e) begin
          failures++;
          $display("FAIL mix_value: got %h required %h", mix_out, e);
        end
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_en[i] = 1'b0; m_freq[i] = '0; m_phase[i] = '0; m_harm[i] = '0;
    end
  endtask

  task automatic test_reset(input string tag);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({rom_rd, rom_addr, mix_out, mix_valid, busy, overrun} !== '0) begin
      failures++;
      $display("FAIL %s reset_state: rd=%b addr=%h mix=%h mv=%b busy=%b ovr=%b required all 0",
               tag, rom_rd, rom_addr, mix_out, mix_valid, busy, overrun);
    end
    Reset = 1'b1;
    model_clear();
  endtask

  task automatic cfg_write(input int v, input bit en, input logic [23:0] f, input logic [1:0] h);
    @(negedge Clk);
    cfg_we = 1'b1; cfg_voice = v[2:0]; cfg_en = en; cfg_freq = f; cfg_harm = h;
    @(negedge Clk);
    cfg_we = 1'b0;
    m_en[v] = en; m_freq[v] = f; m_harm[v] = h;
    if (!en) m_phase[v] = '0;
  endtask

  // One sample tick with optional mid-scan disable (issued in cycle t+3)
  // and optional second strobe at cycle t+1+again_k.
  task automatic do_tick(input int dis_voice, input int again_k, input bit clr_again, input string tag);
    int sum;
    logic [11:0] ea;
    logic [15:0] em;
    sum = 0;
    @(negedge Clk);
    sample_Clk = 1'b1;
    @(negedge Clk);
    sample_Clk = 1'b0;
    for (int k = 0; k < NV; k++) begin
      if (k == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy_start: got %b required 1", tag, busy);
        end
      end
      checks++;
      if (rom_rd !== m_en[k]) begin
        failures++;
        $display("FAIL %s rom_rd v%0d: got %b required %b", tag, k, rom_rd, m_en[k]);
      end else if (m_en[k]) begin
        ea = m_phase[k][23:12];
        checks++;
        if (rom_addr !== ea) begin
          failures++;
          $display("FAIL %s rom_addr v%0d: got %h required %h", tag, k, rom_addr, ea);
        end
        sum += rom_ident ? int'(ea) : int'($signed(rom_const));
        m_phase[k] = m_phase[k] + 24'(m_freq[k] * (32'(m_harm[k]) + 32'd1));
      end
      if (k == 2 && dis_voice >= 0) begin
        cfg_we = 1'b1; cfg_voice = dis_voice[2:0]; cfg_en = 1'b0; cfg_freq = '0; cfg_harm = '0;
        m_en[dis_voice] = 1'b0; m_phase[dis_voice] = '0;
        m_freq[dis_voice] = '0; m_harm[dis_voice] = '0;
      end
      if (k == 3) cfg_we = 1'b0;
      if (again_k >= 0 && k == again_k) begin
        sample_Clk = 1'b1; ovr_clr = clr_again;
      end
      if (again_k >= 0 && k == again_k + 1) begin
        sample_Clk = 1'b0; ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
          failures++;
          $display("FAIL %s overrun_set: got %b required 1", tag, overrun);
        end
      end
      @(negedge Clk);
    end
    em = sat16(sum);
    exp_q.push_back(em);
    checks++;
    if (mix_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s mix_early: mix_valid=%b required 0 at t+%0d", tag, mix_valid, NV + 1);
    end
    @(negedge Clk);
    checks++;
    if (mix_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s latency: mix_valid=%b busy=%b required 1/1 at t+%0d", tag, mix_valid, busy, NV + 2);
    end
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || mix_valid !== 1'b0 || mix_out !== em) begin
      failures++;
      $display("FAIL %s idle_hold: busy=%b mv=%b mix=%h required 0/0/%h", tag, busy, mix_valid, mix_out, em);
    end
  endtask

  task automatic test_single_voice();
    rom_ident = 1'b1;
    cfg_write(0, 1'b1, 24'h001000, 2'd0);
    for (int i = 0; i < 3; i++) do_tick(-1, -1, 1'b0, "single_voice");
  endtask

  task automatic test_harmonic();
    test_reset("harm_reset");
    cfg_write(3, 1'b1, 24'h001000, 2'd1);
    for (int i = 0; i < 3; i++) do_tick(-1, -1, 1'b0, "harmonic");
    cfg_write(5, 1'b1, 24'h000300, 2'd3);
    cfg_write(6, 1'b1, 24'h000500, 2'd2);
    for (int i = 0; i < 2; i++) do_tick(-1, -1, 1'b0, "harm_mix");
  endtask

  task automatic test_saturation();
    test_reset("sat_reset");
    for (int v = 0; v < NV; v++) cfg_write(v, 1'b1, 24'h001000, 2'd0);
    rom_ident = 1'b0;
    rom_const = 16'h7000; do_tick(-1, -1, 1'b0, "sat_pos");
    rom_const = 16'h9000; do_tick(-1, -1, 1'b0, "sat_neg");
    rom_const = 16'h0800; do_tick(-1, -1, 1'b0, "sat_none");
    rom_const = 16'hF800; do_tick(-1, -1, 1'b0, "sat_none_neg");
    rom_ident = 1'b1;
  endtask

  task automatic test_phase_wrap();
    test_reset("wrap_reset");
    cfg_write(0, 1'b1, 24'h800000, 2'd0);
    for (int i = 0; i < 3; i++) do_tick(-1, -1, 1'b0, "phase_wrap");
  endtask

  task automatic test_overrun();
    do_tick(-1, 4, 1'b0, "overrun");
    do_tick(-1, 4, 1'b1, "overrun_clr_race");
    @(negedge Clk);
    ovr_clr = 1'b1;
    @(negedge Clk);
    ovr_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear: got %b required 0", overrun);
    end
  endtask

  task automatic test_midscan_disable();
    test_reset("dis_reset");
    for (int v = 0; v < NV; v++) cfg_write(v, 1'b1, 24'(32'h000100 * (v + 1)), 2'(v));
    do_tick(-1, -1, 1'b0, "pre_disable");
    do_tick(6, -1, 1'b0, "midscan_disable");
    do_tick(-1, -1, 1'b0, "post_disable");
  endtask

  task automatic test_midscan_reset();
    @(negedge Clk);
    sample_Clk = 1'b1;
    @(negedge Clk);
    sample_Clk = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if ({rom_rd, rom_addr, mix_out, mix_valid, busy, overrun} !== '0) begin
      failures++;
      $display("FAIL midscan_reset: rd=%b addr=%h mix=%h mv=%b busy=%b ovr=%b required all 0",
               rom_rd, rom_addr, mix_out, mix_valid, busy, overrun);
    end
    Reset = 1'b1;
    model_clear();
    repeat (14) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midscan_reset_idle: pending=%0d busy=%b required 0/0", exp_q.size(), busy);
    end
  endtask

  initial begin
    model_clear();
    test_reset("reset");
    test_single_voice();
    test_harmonic();
    test_saturation();
    test_phase_wrap();
    test_overrun();
    test_midscan_disable();
    test_midscan_reset();
    repeat (2) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
